// File: rtl/sqrt_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_arbiter_if
// Description : Request/response channels and shared square-root unit
//               handshake bundled for sqrt_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface sqrt_arbiter_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [NUM_REQ-1:0]       resp_ready;
    logic [WIDTH-1:0]         resp_data;
    logic                     sqrt_go;
    logic [WIDTH-1:0]         sqrt_in;
    logic [WIDTH-1:0]         sqrt_out;
    logic                     sqrt_done;
    logic                     busy;

    // Arbiter side
    modport slave (
        input  req_valid, req_data, resp_ready, sqrt_out, sqrt_done,
        output req_ready, resp_valid, resp_data, sqrt_go, sqrt_in, busy
    );

    // Requester / shared-unit side
    modport master (
        output req_valid, req_data, resp_ready, sqrt_out, sqrt_done,
        input  req_ready, resp_valid, resp_data, sqrt_go, sqrt_in, busy
    );
endinterface
`default_nettype wire

// File: rtl/sqrt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_arbiter
// Description : Round-robin arbiter sharing one go/done square-root unit
//               among NUM_REQ requesters, one operation in flight.
//               Optional statistics counters under SQRT_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sqrt_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    sqrt_arbiter_if.slave       bus
`ifdef SQRT_ARB_STATS_EN
    ,
    output logic [31:0]         stat_ops,
    output logic [31:0]         stat_busy
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [WIDTH-1:0]   sqrt_in_q, sqrt_in_d;
    logic [WIDTH-1:0]   resp_data_q, resp_data_d;

    logic               win_found;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   cand_idx;
    logic [NUM_REQ-1:0] win_onehot;
    int                 cand;

    // Round-robin search starting at rr_ptr and wrapping past NUM_REQ-1.
    always_comb begin
        win_found = 1'b0;
        winner    = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand     = (int'(rr_ptr_q) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!win_found && bus.req_valid[cand_idx]) begin
                win_found = 1'b1;
                winner    = cand_idx;
            end
        end
    end

    assign win_onehot = win_found ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << winner)
                                  : '0;

    // Gated by reset_n so no request is accepted while reset is asserted.
    assign bus.req_ready = (state_q == S_IDLE && reset_n) ? win_onehot : '0;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        sqrt_in_d   = sqrt_in_q;
        resp_data_d = resp_data_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    sqrt_in_d = bus.req_data[int'(winner)*WIDTH +: WIDTH];
                    grant_d   = winner;
                    rr_ptr_d  = (winner == IDX_W'(NUM_REQ-1)) ? '0
                                                              : winner + IDX_W'(1);
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.sqrt_done) begin
                    resp_data_d = bus.sqrt_out;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready[grant_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            sqrt_in_q   <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            sqrt_in_q   <= sqrt_in_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign bus.sqrt_go    = (state_q == S_ISSUE);
    assign bus.sqrt_in    = sqrt_in_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_valid = (state_q == S_RESP)
                          ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q) : '0;

`ifdef SQRT_ARB_STATS_EN
    logic [31:0] stat_ops_q;
    logic [31:0] stat_busy_q;
    logic        resp_hs;

    assign resp_hs = (state_q == S_RESP) && bus.resp_ready[grant_q];

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_ops_q  <= '0;
            stat_busy_q <= '0;
        end else begin
            if (resp_hs && stat_ops_q != 32'hFFFF_FFFF) begin
                stat_ops_q <= stat_ops_q + 32'd1;
            end
            if (bus.busy && stat_busy_q != 32'hFFFF_FFFF) begin
                stat_busy_q <= stat_busy_q + 32'd1;
            end
        end
    end

    assign stat_ops  = stat_ops_q;
    assign stat_busy = stat_busy_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sqrt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sqrt_arbiter
// Description : Directed self-checking bench for sqrt_arbiter with a
//               behavioural multi-cycle square-root unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sqrt_arbiter;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 4;
    localparam int LAT     = 6;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;
    int   go_cnt;
    int   busy_cnt;

    sqrt_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

`ifdef SQRT_ARB_STATS_EN
    logic [31:0] stat_ops;
    logic [31:0] stat_busy;
`endif

    sqrt_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus)
`ifdef SQRT_ARB_STATS_EN
        ,
        .stat_ops (stat_ops),
        .stat_busy(stat_busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] isqrt(input logic [31:0] x);
        logic [31:0] r;
        logic [31:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (32'd1 << b);
            if (64'(t) * 64'(t) <= 64'(x)) r = t;
        end
        return r;
    endfunction

    // Shared unit model; deliberately not reset so a stale done can arrive.
    int          unit_cnt;
    logic [31:0] unit_op;
    initial begin
        unit_cnt      = 0;
        unit_op       = '0;
        bus.sqrt_done = 1'b0;
        bus.sqrt_out  = '0;
    end
    always @(posedge clk) begin
        bus.sqrt_done <= 1'b0;
        if (unit_cnt != 0) begin
            unit_cnt <= unit_cnt - 1;
            if (unit_cnt == 1) begin
                bus.sqrt_done <= 1'b1;
                bus.sqrt_out  <= isqrt(unit_op);
            end
        end else if (bus.sqrt_go) begin
            unit_op  <= bus.sqrt_in;
            unit_cnt <= LAT;
        end
    end

    always @(posedge clk) if (bus.sqrt_go) go_cnt <= go_cnt + 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) busy_cnt <= 0;
        else if (bus.busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (bus.req_ready != '0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_resp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (bus.resp_valid != '0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Full transaction: grant check, drop valid, response check, handshake.
    task automatic do_op(input int idx, input logic [31:0] exp, input string tag);
        bit ok;
        wait_ready(ok);
        if (!ok) check({tag, "_ready_timeout"}, 0, 1);
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'(4'b0001 << idx));
        @(negedge clk);
        bus.req_valid[idx] = 1'b0;
        wait_resp(ok);
        if (!ok) check({tag, "_resp_timeout"}, 0, 1);
        check({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'(4'b0001 << idx));
        check({tag, "_resp_data"}, 64'(bus.resp_data), 64'(exp));
        bus.resp_ready[idx] = 1'b1;
        @(negedge clk);
        bus.resp_ready = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int go0;
        int stale;
        n_checks       = 0;
        n_errors       = 0;
        go_cnt         = 0;
        reset_n        = 1'b0;
        bus.req_valid  = 4'b1111;
        bus.req_data   = {32'd4, 32'd3, 32'd2, 32'd1};
        bus.resp_ready = '0;

        // Reset values, req_ready gated while reset is asserted
        @(negedge clk);
        #1;
        check("rst_busy",       64'(bus.busy),       0);
        check("rst_go",         64'(bus.sqrt_go),    0);
        check("rst_sqrt_in",    64'(bus.sqrt_in),    0);
        check("rst_resp_valid", 64'(bus.resp_valid), 0);
        check("rst_resp_data",  64'(bus.resp_data),  0);
        check("rst_req_ready",  64'(bus.req_ready),  0);
        bus.req_valid = '0;
        @(negedge clk);
        reset_n = 1'b1;

        // 1: single request, 144 -> 12
        @(negedge clk);
        bus.req_data[31:0] = 32'd144;
        bus.req_valid      = 4'b0001;
        go0 = go_cnt;
        do_op(0, 32'd12, "t1");
        #1;
        check("t1_busy_after", 64'(bus.busy), 0);
        check("t1_go_pulses",  64'(go_cnt - go0), 1);

        // 2: all four at once, served 0..3
        do_reset();
        bus.req_data  = {32'd0, 32'd1000000, 32'd81, 32'd16};
        bus.req_valid = 4'b1111;
        do_op(0, 32'd4,    "t2_r0");
        do_op(1, 32'd9,    "t2_r1");
        do_op(2, 32'd1000, "t2_r2");
        do_op(3, 32'd0,    "t2_r3");

        // 3: rr_ptr back at 0, so req1 beats req3
        bus.req_data  = {32'hFFFF_FFFF, 32'd0, 32'd2, 32'd0};
        bus.req_valid = 4'b1010;
        do_op(1, 32'd1,     "t3_r1");
        do_op(3, 32'd65535, "t3_r3");

        // 4: response stalled 10 cycles with a pending request
        bus.req_data[95:64] = 32'd9;
        bus.req_valid       = 4'b0100;
        wait_ready(ok);
        check("t4_req_ready", 64'(bus.req_ready), 64'(4'b0100));
        @(negedge clk);
        bus.req_valid = '0;
        wait_resp(ok);
        if (!ok) check("t4_resp_timeout", 0, 1);
        bus.req_data[31:0] = 32'd25;
        bus.req_valid      = 4'b0001;
        go0 = go_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("t4_hold_valid", 64'(bus.resp_valid), 64'(4'b0100));
            check("t4_hold_data",  64'(bus.resp_data),  3);
            check("t4_hold_ready", 64'(bus.req_ready),  0);
        end
        check("t4_no_go", 64'(go_cnt - go0), 0);
        bus.resp_ready = 4'b1011;
        @(negedge clk);
        #1;
        check("t4_other_ready_ignored", 64'(bus.resp_valid), 64'(4'b0100));
        bus.resp_ready = 4'b0100;
        @(negedge clk);
        bus.resp_ready = '0;
        do_op(0, 32'd5, "t4_r0");

        // 5: reset during WAIT, stale done ignored
        bus.req_data[95:64] = 32'd100;
        bus.req_valid       = 4'b0100;
        wait_ready(ok);
        check("t5_req_ready", 64'(bus.req_ready), 64'(4'b0100));
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n       = 1'b0;
        bus.req_valid = 4'b0010;
        #1;
        check("t5_busy",       64'(bus.busy),       0);
        check("t5_go",         64'(bus.sqrt_go),    0);
        check("t5_sqrt_in",    64'(bus.sqrt_in),    0);
        check("t5_resp_valid", 64'(bus.resp_valid), 0);
        check("t5_resp_data",  64'(bus.resp_data),  0);
        check("t5_req_ready",  64'(bus.req_ready),  0);
        @(negedge clk);
        reset_n       = 1'b1;
        bus.req_valid = '0;
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (bus.resp_valid != '0 || bus.busy) stale++;
        end
        check("t5_stale_done_ignored", 64'(stale), 0);
        bus.req_data[63:32] = 32'd49;
        bus.req_valid       = 4'b0010;
        do_op(1, 32'd7, "t5_r1");

`ifdef SQRT_ARB_STATS_EN
        // 6: statistics over three operations
        do_reset();
        bus.req_data  = {32'd0, 32'd16, 32'd9, 32'd4};
        bus.req_valid = 4'b0111;
        do_op(0, 32'd2, "t6_r0");
        do_op(1, 32'd3, "t6_r1");
        do_op(2, 32'd4, "t6_r2");
        #1;
        check("t6_stat_ops",  64'(stat_ops), 3);
        check("t6_stat_busy", 64'(stat_busy), 64'(busy_cnt));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
